// File: rtl/spi_nor_shifter.sv
// Byte-level SPI mode-0 master: serialises bytes on s_mosi, captures s_miso, owns CS framing.
// Optional macro SPI_LSB_FIRST_EN selects LSB-first bit order for both directions.
`timescale 1ns/1ps
module spi_nor_shifter #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 3
) (
  input  logic       p_clk,
  input  logic       p_reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       s_clk,
  output logic       s_css,
  output logic       s_mosi,
  input  logic       s_miso
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic [3:0] half_cnt;
  logic       last_q;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;

  logic accept;
  logic half_done;
  logic rise;
  logic fall;
  logic byte_done;

  function automatic logic first_bit(input logic [7:0] b);
`ifdef SPI_LSB_FIRST_EN
    return b[0];
`else
    return b[7];
`endif
  endfunction

  function automatic logic [7:0] tx_advance(input logic [7:0] b);
`ifdef SPI_LSB_FIRST_EN
    return {1'b0, b[7:1]};
`else
    return {b[6:0], 1'b0};
`endif
  endfunction

  function automatic logic [7:0] rx_insert(input logic [7:0] b, input logic bit_in);
`ifdef SPI_LSB_FIRST_EN
    return {bit_in, b[7:1]};
`else
    return {b[6:0], bit_in};
`endif
  endfunction

  assign tx_ready  = ((state == ST_IDLE) || (state == ST_WAIT)) && !p_reset;
  assign busy      = (state != ST_IDLE);
  assign accept    = tx_valid && tx_ready;
  // The divider only runs in SHIFT and restarts at every accept, so s_clk phase is fresh per byte.
  assign half_done = (state == ST_SHIFT) && (cnt == DIV_LAST);
  assign rise      = half_done && !s_clk;
  assign fall      = half_done && s_clk;
  assign byte_done = fall && (half_cnt == 4'd15);

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      state    <= ST_IDLE;
      cnt      <= 8'd0;
      half_cnt <= 4'd0;
      last_q   <= 1'b0;
      s_clk    <= 1'b0;
      s_css    <= 1'b1;
      s_mosi   <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_WAIT: begin
          if (accept) begin
            state    <= ST_SHIFT;
            cnt      <= 8'd0;
            half_cnt <= 4'd0;
            last_q   <= tx_last;
            s_css    <= 1'b0;
            s_mosi   <= first_bit(tx_data);
          end
        end
        ST_SHIFT: begin
          if (half_done) begin
            cnt      <= 8'd0;
            s_clk    <= ~s_clk;
            half_cnt <= half_cnt + 4'd1;
            if (byte_done) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_sh;
              state    <= last_q ? ST_TRAIL : ST_WAIT;
            end else if (fall) begin
              s_mosi <= first_bit(tx_advance(tx_sh));
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_TRAIL: begin
          if (cnt == DIV_LAST) begin
            cnt    <= 8'd0;
            s_css  <= 1'b1;
            s_mosi <= 1'b0;
            state  <= ST_GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= 8'd0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shift registers carry data only; their contents are don't-care until the next accept.
  always_ff @(posedge p_clk) begin
    if (accept) begin
      tx_sh <= tx_data;
    end else if (fall) begin
      tx_sh <= tx_advance(tx_sh);
    end
    if (rise) begin
      rx_sh <= rx_insert(rx_sh, s_miso);
    end
  end

endmodule

// File: tb/tb_spi_nor_shifter.sv
// Scoreboard bench for spi_nor_shifter: directed bytes, slave model, framing/timing checks.
`timescale 1ns/1ps
module tb_spi_nor_shifter;

  logic p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  logic       p_reset = 1'b0;
  logic       tx_valid = 1'b0, tx_last = 1'b0, s_miso = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, rx_valid, busy, s_clk, s_css, s_mosi;
  logic [7:0] rx_data;

  logic       tx_valid_b = 1'b0, tx_last_b = 1'b0;
  logic [7:0] tx_data_b = 8'h00;
  logic       tx_ready_b, rx_valid_b, busy_b, s_clk_b, s_css_b, s_mosi_b, s_miso_b;
  logic [7:0] rx_data_b;

  assign s_miso_b = s_mosi_b;

  spi_nor_shifter #(.CLK_DIV(2), .CS_GAP(3)) dut (
    .p_clk(p_clk), .p_reset(p_reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .s_clk(s_clk), .s_css(s_css), .s_mosi(s_mosi), .s_miso(s_miso));

  spi_nor_shifter #(.CLK_DIV(1), .CS_GAP(3)) dut_b (
    .p_clk(p_clk), .p_reset(p_reset), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .tx_data(tx_data_b), .tx_last(tx_last_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
    .busy(busy_b), .s_clk(s_clk_b), .s_css(s_css_b), .s_mosi(s_mosi_b), .s_miso(s_miso_b));

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_rx_q[$], exp_tx_q[$], miso_q[$], got_tx_q[$], exp_b_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int bidx(input int k);
`ifdef SPI_LSB_FIRST_EN
    return k;
`else
    return 7 - k;
`endif
  endfunction

  // Slave model: drives s_miso bit by bit and captures s_mosi on each s_clk rise.
  logic [7:0] cur_miso = 8'h00, cap = 8'h00;
  int  bitcnt = 0;
  bit  loaded = 0;
  logic sl_sclk_prev = 1'b0;
  always @(negedge p_clk) begin
    if (p_reset) begin
      bitcnt = 0; loaded = 0; sl_sclk_prev = 1'b0; s_miso = 1'b0;
    end else begin
      if (s_clk && !sl_sclk_prev) begin
        cap[bidx(bitcnt)] = s_mosi;
        bitcnt++;
        if (bitcnt == 8) begin
          got_tx_q.push_back(cap);
          bitcnt = 0;
          loaded = 0;
        end
      end
      sl_sclk_prev = s_clk;
      if (!loaded && miso_q.size() > 0) begin
        cur_miso = miso_q.pop_front();
        loaded = 1;
      end
      s_miso = cur_miso[bidx(bitcnt)];
    end
  end

  int cyc = 0;
  always @(posedge p_clk) cyc <= cyc + 1;

  // Monitor for the CLK_DIV=2 instance: event counters plus scoreboard pops.
  int rise_cnt = 0, rxv_cnt = 0, wait_cnt = 0, css_rise_n = 0;
  int css_rise_cyc = 0, css_fall_cyc = 0;
  logic mon_sclk_prev = 1'b0, css_prev = 1'b1, rxv_prev = 1'b0;
  always @(negedge p_clk) begin
    if (!p_reset) begin
      if (s_clk && !mon_sclk_prev) rise_cnt++;
      if (tx_ready && !s_css) wait_cnt++;
      if (s_css && !css_prev) begin css_rise_cyc = cyc; css_rise_n++; end
      if (!s_css && css_prev) css_fall_cyc = cyc;
      if (rx_valid) begin
        rxv_cnt++;
        check("rx_valid_one_cycle", rxv_prev, 1'b0);
        if (exp_rx_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rx_unexpected: got rx_data 0x%0h, required no rx_valid", rx_data);
        end else begin
          check("rx_data", rx_data, exp_rx_q.pop_front());
        end
        if (exp_tx_q.size() == 0 || got_tx_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL mosi_byte: got %0d captured bytes, required 1", got_tx_q.size());
        end else begin
          check("mosi_byte", got_tx_q.pop_front(), exp_tx_q.pop_front());
        end
      end
    end
    mon_sclk_prev = s_clk;
    css_prev = s_css;
    rxv_prev = rx_valid;
  end

  always @(negedge p_clk) begin
    if (!p_reset && rx_valid_b) begin
      if (exp_b_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rx_b_unexpected: got rx_data 0x%0h, required no rx_valid", rx_data_b);
      end else begin
        check("rx_data_b", rx_data_b, exp_b_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l, input logic [7:0] mi, output int waited);
    int n;
    logic fb;
    n = 0;
`ifdef SPI_LSB_FIRST_EN
    fb = d[0];
`else
    fb = d[7];
`endif
    exp_rx_q.push_back(mi);
    exp_tx_q.push_back(d);
    miso_q.push_back(mi);
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    while (!tx_ready && n < 500) begin
      @(negedge p_clk);
      n++;
    end
    waited = n;
    if (!tx_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: tx_ready 0 after %0d cycles, required 1", n);
    end else begin
      @(posedge p_clk);
      @(negedge p_clk);
      check("first_mosi_bit", s_mosi, fb);
      check("css_low_after_accept", s_css, 1'b0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge p_clk);
      n++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, cnt, hi, ok, r0, w0, rx0, cr0, n, tog;
    logic prev;
    #1 p_reset = 1'b1;
    repeat (3) @(negedge p_clk);
    check("rst_s_clk", s_clk, 1'b0);
    check("rst_s_css", s_css, 1'b1);
    check("rst_s_mosi", s_mosi, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_b_s_css", s_css_b, 1'b1);
    p_reset = 1'b0;
    @(negedge p_clk);
    check("idle_tx_ready", tx_ready, 1'b1);

    // Single byte 9F, slave returns C2
    r0 = rise_cnt;
    send(8'h9F, 1'b1, 8'hC2, w);
    tx_valid = 1'b0;
    cnt = 0; hi = 0;
    while (!s_css && cnt < 100) begin
      cnt++;
      if (s_clk) hi++;
      @(negedge p_clk);
    end
    check("t1_css_low_cycles", cnt, 34);
    check("t1_sclk_high_cycles", hi, 16);
    check("t1_sclk_rises", rise_cnt - r0, 8);
    ok = 0;
    for (int i = 0; i < 3; i++) begin
      if (s_css && !tx_ready) ok++;
      @(negedge p_clk);
    end
    check("t1_gap_css_high", ok, 3);
    check("t1_ready_after_gap", tx_ready, 1'b1);

    // Four-byte frame, tx_valid held
    r0 = rise_cnt; w0 = wait_cnt; rx0 = rxv_cnt; cr0 = css_rise_n;
    send(8'h03, 1'b0, 8'h11, w);
    send(8'h12, 1'b0, 8'h22, w);
    send(8'h34, 1'b0, 8'h33, w);
    send(8'h56, 1'b1, 8'h44, w);
    tx_valid = 1'b0;
    wait_idle();
    check("t2_sclk_rises", rise_cnt - r0, 32);
    check("t2_wait_ready_cycles", wait_cnt - w0, 3);
    check("t2_rx_pulses", rxv_cnt - rx0, 4);
    check("t2_css_rises", css_rise_n - cr0, 1);

    // tx_valid held across the gap
    send(8'h11, 1'b1, 8'hA0, w);
    send(8'h22, 1'b1, 8'h0F, w);
    check("t3_ready_wait_cycles", w, 37);
    @(negedge p_clk);
    check("t3_css_rise_to_fall", css_fall_cyc - css_rise_cyc, 4);
    tx_valid = 1'b0;
    wait_idle();

    // Reset during the 5th s_clk high of byte 2
    r0 = rise_cnt; rx0 = rxv_cnt;
    send(8'h03, 1'b0, 8'hF0, w);
    send(8'hB7, 1'b0, 8'h0C, w);
    n = 0;
    while ((rise_cnt - r0) < 13 && n < 200) begin
      @(negedge p_clk);
      n++;
    end
    check("t4_reached_5th_high", s_clk, 1'b1);
    p_reset = 1'b1;
    tx_valid = 1'b0;
    exp_rx_q.delete(); exp_tx_q.delete(); miso_q.delete(); got_tx_q.delete();
    #1;
    check("t4_rst_s_css", s_css, 1'b1);
    check("t4_rst_s_clk", s_clk, 1'b0);
    check("t4_rst_s_mosi", s_mosi, 1'b0);
    check("t4_rst_tx_ready", tx_ready, 1'b0);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_rx_data", rx_data, 8'h00);
    repeat (2) @(negedge p_clk);
    check("t4_no_rx_for_abort", rxv_cnt - rx0, 1);
    p_reset = 1'b0;
    @(negedge p_clk);
    check("t4_ready_after_reset", tx_ready, 1'b1);
    send(8'hA5, 1'b1, 8'h3C, w);
    tx_valid = 1'b0;
    wait_idle();
    check("t4_rx_pulses", rxv_cnt - rx0, 2);

    // CLK_DIV=1 instance with echoed s_miso
    exp_b_q.push_back(8'h5A);
    tx_data_b = 8'h5A; tx_last_b = 1'b1; tx_valid_b = 1'b1;
    check("t5_ready_b", tx_ready_b, 1'b1);
    @(posedge p_clk);
    @(negedge p_clk);
    tx_valid_b = 1'b0;
    n = 0; tog = 0; prev = s_clk_b;
    while (!rx_valid_b && n < 40) begin
      @(negedge p_clk);
      n++;
      if (s_clk_b != prev) tog++;
      prev = s_clk_b;
    end
    check("t5_rx_latency", n, 16);
    check("t5_sclk_toggles", tog, 16);
    n = 0;
    while (busy_b && n < 100) begin
      @(negedge p_clk);
      n++;
    end
    check("t5_idle_b", busy_b, 1'b0);

    // Single-bit pattern shows bit order on both lines
    send(8'h01, 1'b1, 8'h01, w);
    tx_valid = 1'b0;
    wait_idle();

    repeat (5) @(negedge p_clk);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("rx_b_queue_drained", exp_b_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
